// File: rtl/ll_req_queue.sv
// ll_req_queue: host-side request FIFO in front of the linked-list request/response
// interface. Requests are tagged with a wrapping ID and issued one at a time. Each
// response is returned to the host through a single-entry valid/ready register.
// Build with LL_REQ_QUEUE_STATS_EN defined to add the issued/error statistics counters.
module ll_req_queue #(
    parameter int DEPTH        = 4,
    parameter int PTR_WD       = 8,
    parameter int WR_DATA_WD   = 32,
    parameter int REQ_TYPE_WD  = 4,
    parameter int RESP_TYPE_WD = 4,
    parameter int ID_WD        = 4
`ifdef LL_REQ_QUEUE_STATS_EN
    ,
    parameter logic [RESP_TYPE_WD-1:0] RESP_ERR = '0
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    host_req_vld,
    output logic                    host_req_rdy,
    input  logic [REQ_TYPE_WD-1:0]  host_req_type,
    input  logic [PTR_WD-1:0]       host_req_pos,
    input  logic [WR_DATA_WD-1:0]   host_req_data,
    output logic                    host_resp_vld,
    input  logic                    host_resp_rdy,
    output logic [RESP_TYPE_WD-1:0] host_resp_type,
    output logic [WR_DATA_WD-1:0]   host_resp_data,
    output logic                    host_resp_data_vld,
    output logic [ID_WD-1:0]        host_resp_id,
    output logic                    req_vld,
    output logic [REQ_TYPE_WD-1:0]  req_type,
    output logic [PTR_WD-1:0]       req_pos,
    output logic [WR_DATA_WD-1:0]   req_data,
    input  logic                    intf_ready,
    input  logic                    resp_vld,
    input  logic [RESP_TYPE_WD-1:0] resp_type,
    input  logic [WR_DATA_WD-1:0]   resp_data,
    input  logic                    resp_data_vld,
    output logic                    resp_taken,
    output logic [$clog2(DEPTH):0]  q_count
`ifdef LL_REQ_QUEUE_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [15:0]             stat_issued,
    output logic [15:0]             stat_errors
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                  state;
    logic [REQ_TYPE_WD-1:0]  mem_type [DEPTH];
    logic [PTR_WD-1:0]       mem_pos  [DEPTH];
    logic [WR_DATA_WD-1:0]   mem_data [DEPTH];
    logic [ID_WD-1:0]        mem_id   [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [ID_WD-1:0]        id_cnt;
    logic [ID_WD-1:0]        inflight_id;
    logic [CW-1:0]           count_next;
    logic                    push;
    logic                    pop;
    logic                    capture;

    assign push    = host_req_vld && host_req_rdy;
    // The head is only popped when IDLE launches it, so pop never sees an empty FIFO.
    assign pop     = (state == IDLE) && (q_count != '0) && intf_ready;
    // The response may be taken when the output register is free or draining this cycle.
    assign capture = (state == WAIT) && resp_vld && (!host_resp_vld || host_resp_rdy);

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = q_count;
        if (push && !pop) begin
            count_next = q_count + 1'b1;
        end else if (!push && pop) begin
            count_next = q_count - 1'b1;
        end
    end

    // FIFO storage: written on push, never reset (contents are qualified by q_count).
    always_ff @(posedge clk) begin
        if (push) begin
            mem_type[wr_ptr] <= host_req_type;
            mem_pos[wr_ptr]  <= host_req_pos;
            mem_data[wr_ptr] <= host_req_data;
            mem_id[wr_ptr]   <= id_cnt;
        end
    end

    // FIFO pointers, occupancy, registered ready and the wrapping request tag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_count      <= '0;
            host_req_rdy <= 1'b1;
            id_cnt       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                id_cnt <= id_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            q_count      <= count_next;
            host_req_rdy <= (count_next != CW'(DEPTH));
        end
    end

    // Issue/wait sequencer with registered interface outputs and the host response register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            req_vld            <= 1'b0;
            req_type           <= '0;
            req_pos            <= '0;
            req_data           <= '0;
            inflight_id        <= '0;
            resp_taken         <= 1'b0;
            host_resp_vld      <= 1'b0;
            host_resp_type     <= '0;
            host_resp_data     <= '0;
            host_resp_data_vld <= 1'b0;
            host_resp_id       <= '0;
        end else begin
            req_vld    <= 1'b0;
            resp_taken <= 1'b0;
            if (host_resp_rdy) begin
                host_resp_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        req_vld     <= 1'b1;
                        req_type    <= mem_type[rd_ptr];
                        req_pos     <= mem_pos[rd_ptr];
                        req_data    <= mem_data[rd_ptr];
                        inflight_id <= mem_id[rd_ptr];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        host_resp_vld      <= 1'b1;
                        host_resp_type     <= resp_type;
                        host_resp_data     <= resp_data;
                        host_resp_data_vld <= resp_data_vld;
                        host_resp_id       <= inflight_id;
                        resp_taken         <= 1'b1;
                        state              <= GAP;
                    end
                end
                GAP: begin
                    // One dead cycle so a still-high resp_vld or stale intf_ready is ignored.
                    req_type <= '0;
                    req_pos  <= '0;
                    req_data <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LL_REQ_QUEUE_STATS_EN
    // Saturating issue and error counters; clear overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset_n || stat_clr) begin
            stat_issued <= '0;
            stat_errors <= '0;
        end else begin
            if (pop && (stat_issued != 16'hFFFF)) begin
                stat_issued <= stat_issued + 1'b1;
            end
            if (capture && (resp_type == RESP_ERR) && (stat_errors != 16'hFFFF)) begin
                stat_errors <= stat_errors + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ll_req_queue.sv
// Bench for ll_req_queue: directed stimulus with a scoreboard of expected
// interface requests and host responses, popped by monitors on the falling edge.
`timescale 1ns/1ps
module tb_ll_req_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_req_vld;
    logic        host_req_rdy;
    logic [3:0]  host_req_type;
    logic [7:0]  host_req_pos;
    logic [31:0] host_req_data;
    logic        host_resp_vld;
    logic        host_resp_rdy;
    logic [3:0]  host_resp_type;
    logic [31:0] host_resp_data;
    logic        host_resp_data_vld;
    logic [3:0]  host_resp_id;
    logic        req_vld;
    logic [3:0]  req_type;
    logic [7:0]  req_pos;
    logic [31:0] req_data;
    logic        intf_ready;
    logic        resp_vld;
    logic [3:0]  resp_type;
    logic [31:0] resp_data;
    logic        resp_data_vld;
    logic        resp_taken;
    logic [2:0]  q_count;
`ifdef LL_REQ_QUEUE_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_issued;
    logic [15:0] stat_errors;
`endif

    always #5 clk = ~clk;

    ll_req_queue #(
        .DEPTH(4), .PTR_WD(8), .WR_DATA_WD(32), .REQ_TYPE_WD(4), .RESP_TYPE_WD(4), .ID_WD(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .host_req_vld(host_req_vld), .host_req_rdy(host_req_rdy),
        .host_req_type(host_req_type), .host_req_pos(host_req_pos), .host_req_data(host_req_data),
        .host_resp_vld(host_resp_vld), .host_resp_rdy(host_resp_rdy),
        .host_resp_type(host_resp_type), .host_resp_data(host_resp_data),
        .host_resp_data_vld(host_resp_data_vld), .host_resp_id(host_resp_id),
        .req_vld(req_vld), .req_type(req_type), .req_pos(req_pos), .req_data(req_data),
        .intf_ready(intf_ready), .resp_vld(resp_vld), .resp_type(resp_type),
        .resp_data(resp_data), .resp_data_vld(resp_data_vld),
        .resp_taken(resp_taken), .q_count(q_count)
`ifdef LL_REQ_QUEUE_STATS_EN
        , .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_errors(stat_errors)
`endif
    );

    typedef struct packed {logic [3:0] t; logic [7:0] p; logic [31:0] d;} req_t;
    typedef struct packed {logic [3:0] t; logic [31:0] d; logic dv; logic [3:0] id;} resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];
    req_t  mon_req;
    resp_t mon_resp;
    int    vectors = 0;
    int    miscompares = 0;
    logic  prev_req_vld = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Interface-side monitor: every req_vld pulse must match the next queued request.
    always @(negedge clk) begin
        if (reset_n && req_vld) begin
            chk("req_vld_one_cycle", prev_req_vld, 0);
            chk("req_expected_pending", exp_req.size() != 0, 1);
            if (exp_req.size() != 0) begin
                mon_req = exp_req.pop_front();
                chk("req_type", req_type, mon_req.t);
                chk("req_pos", req_pos, mon_req.p);
                chk("req_data", req_data, mon_req.d);
            end
        end
        prev_req_vld = req_vld;
    end

    // Host-side monitor: every accepted response must match the next queued response.
    always @(negedge clk) begin
        if (reset_n && host_resp_vld && host_resp_rdy) begin
            chk("resp_expected_pending", exp_resp.size() != 0, 1);
            if (exp_resp.size() != 0) begin
                mon_resp = exp_resp.pop_front();
                chk("host_resp_type", host_resp_type, mon_resp.t);
                chk("host_resp_data", host_resp_data, mon_resp.d);
                chk("host_resp_data_vld", host_resp_data_vld, mon_resp.dv);
                chk("host_resp_id", host_resp_id, mon_resp.id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        host_req_vld = 1'b0;
        resp_vld     = 1'b0;
`ifdef LL_REQ_QUEUE_STATS_EN
        stat_clr     = 1'b0;
`endif
        tick();
        tick();
        exp_req.delete();
        exp_resp.delete();
        reset_n = 1'b1;
    endtask

    task automatic drive_req(input logic [3:0] t, input logic [7:0] p, input logic [31:0] d);
        host_req_vld  = 1'b1;
        host_req_type = t;
        host_req_pos  = p;
        host_req_data = d;
        exp_req.push_back('{t, p, d});
    endtask

    task automatic finish_push();
        int n;
        n = 0;
        while (!host_req_rdy && n < 40) begin
            tick();
            n++;
        end
        chk("push_accepted", host_req_rdy, 1);
        tick();
        host_req_vld = 1'b0;
    endtask

    task automatic push(input logic [3:0] t, input logic [7:0] p, input logic [31:0] d);
        drive_req(t, p, d);
        finish_push();
    endtask

    task automatic respond(input logic [3:0] t, input logic [31:0] d, input logic dv, input logic [3:0] id);
        int n;
        resp_type     = t;
        resp_data     = d;
        resp_data_vld = dv;
        resp_vld      = 1'b1;
        exp_resp.push_back('{t, d, dv, id});
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_taken && n < 40);
        chk("resp_taken_seen", resp_taken, 1);
        resp_vld = 1'b0;
        tick();
        chk("resp_taken_pulse", resp_taken, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        host_req_vld  = 1'b0;
        host_req_type = '0;
        host_req_pos  = '0;
        host_req_data = '0;
        host_resp_rdy = 1'b1;
        intf_ready    = 1'b1;
        resp_vld      = 1'b0;
        resp_type     = '0;
        resp_data     = '0;
        resp_data_vld = 1'b0;
`ifdef LL_REQ_QUEUE_STATS_EN
        stat_clr      = 1'b0;
`endif

        // Test 1: reset state, single request, response with id 0
        do_reset();
        chk("rst_host_req_rdy", host_req_rdy, 1);
        chk("rst_q_count", q_count, 0);
        chk("rst_req_vld", req_vld, 0);
        chk("rst_req_data", req_data, 0);
        chk("rst_host_resp_vld", host_resp_vld, 0);
        chk("rst_resp_taken", resp_taken, 0);
        drive_req(4'd3, 8'd2, 32'hA5);
        tick();
        host_req_vld = 1'b0;
        chk("t1_q_count_after_push", q_count, 1);
        chk("t1_req_vld_push_plus1", req_vld, 0);
        tick();
        chk("t1_req_vld_push_plus2", req_vld, 1);
        chk("t1_q_count_after_pop", q_count, 0);
        tick();
        chk("t1_req_vld_low_after", req_vld, 0);
        chk("t1_req_data_hold", req_data, 32'hA5);
        respond(4'd1, 32'hA5, 1'b1, 4'd0);
        chk("t1_req_data_cleared", req_data, 0);
        chk("t1_host_resp_vld_drained", host_resp_vld, 0);

        // Test 2: fill FIFO with interface busy, stall the 5th, then drain in order
        do_reset();
        intf_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'd4, 8'(8'h10 + i), 32'(32'h100 + i));
        chk("t2_q_count_full", q_count, 4);
        chk("t2_host_req_rdy_full", host_req_rdy, 0);
        drive_req(4'd4, 8'h14, 32'h104);
        repeat (3) tick();
        chk("t2_q_count_stalled", q_count, 4);
        chk("t2_rdy_stalled", host_req_rdy, 0);
        intf_ready = 1'b1;
        finish_push();
        for (int i = 0; i < 5; i++) respond(4'd2, 32'(32'h200 + i), 1'b1, 4'(i));

        // Test 3: output register backpressure blocks the second capture
        do_reset();
        host_resp_rdy = 1'b0;
        push(4'd5, 8'h31, 32'h3000);
        push(4'd6, 8'h32, 32'h3100);
        respond(4'd1, 32'h3001, 1'b1, 4'd0);
        resp_type     = 4'd2;
        resp_data     = 32'h3101;
        resp_data_vld = 1'b0;
        resp_vld      = 1'b1;
        exp_resp.push_back('{4'd2, 32'h3101, 1'b0, 4'd1});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_resp_taken_blocked", resp_taken, 0);
        end
        chk("t3_host_resp_data_held", host_resp_data, 32'h3001);
        host_resp_rdy = 1'b1;
        tick();
        host_resp_rdy = 1'b0;
        resp_vld      = 1'b0;
        chk("t3_resp_taken_capture", resp_taken, 1);
        chk("t3_host_resp_vld_new", host_resp_vld, 1);
        chk("t3_host_resp_data_new", host_resp_data, 32'h3101);
        tick();
        chk("t3_resp_taken_once", resp_taken, 0);
        host_resp_rdy = 1'b1;
        tick();
        chk("t3_host_resp_vld_drained", host_resp_vld, 0);

        // Test 4: 17 requests, ids wrap 15 -> 0
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(4'd1, 8'(i), 32'(32'h1000 + i));
            respond(4'd2, 32'(32'h2000 + i), 1'(i & 1), 4'(i % 16));
        end

        // Test 5: reset while waiting with two entries queued
        do_reset();
        push(4'd7, 8'h51, 32'h5000);
        push(4'd7, 8'h52, 32'h5001);
        push(4'd7, 8'h53, 32'h5002);
        tick();
        chk("t5_q_count_before", q_count, 2);
        reset_n = 1'b0;
        exp_req.delete();
        exp_resp.delete();
        tick();
        chk("t5_q_count_reset", q_count, 0);
        chk("t5_req_vld_reset", req_vld, 0);
        chk("t5_host_resp_vld_reset", host_resp_vld, 0);
        chk("t5_host_req_rdy_reset", host_req_rdy, 1);
        reset_n = 1'b1;
        push(4'd8, 8'h54, 32'h5003);
        respond(4'd3, 32'h5555, 1'b1, 4'd0);

`ifdef LL_REQ_QUEUE_STATS_EN
        // Test 6: statistics counters and clear
        do_reset();
        chk("t6_stat_issued_rst", stat_issued, 0);
        chk("t6_stat_errors_rst", stat_errors, 0);
        push(4'd1, 8'h61, 32'h6000);
        respond(4'd1, 32'h6001, 1'b1, 4'd0);
        push(4'd9, 8'h62, 32'h6002);
        respond(4'd0, 32'h6003, 1'b0, 4'd1);
        push(4'd2, 8'h63, 32'h6004);
        respond(4'd2, 32'h6005, 1'b1, 4'd2);
        chk("t6_stat_issued", stat_issued, 3);
        chk("t6_stat_errors", stat_errors, 1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("t6_stat_issued_clr", stat_issued, 0);
        chk("t6_stat_errors_clr", stat_errors, 0);
`endif

        repeat (3) tick();
        chk("exp_req_drained", exp_req.size(), 0);
        chk("exp_resp_drained", exp_resp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
